// File: rtl/arena_map_writer.sv
`default_nettype none
// ============================================================================
// Module   : arena_map_writer
// Purpose  : Producer side of the tile-map interface for vga640x480.
//            Accepts arena-edit and bomb-placement commands into a shadow
//            arena and runs up to SLOTS bomb timers in frame ticks. At every
//            falling edge of vsync it commits arena_flat and bomb_flat
//            together, so the display never sees a half-updated frame.
// Ports    : pixel_clk  - sole clock
//            rst_n      - asynchronous active-low reset
//            vsync      - active-low vsync from the display timing
//            cmd_*      - valid/ready command port (op, row, col, data)
//            err        - one-cycle pulse: accepted command was rejected
//            frame_tick - one-cycle pulse when new maps appear
//            arena_flat - committed arena, cell k at [2k+1:2k]
//            bomb_flat  - committed bomb map (0 none,1 new,2 late,3 blast)
// Revision : 1.0 - initial release
// ============================================================================
module arena_map_writer #(
    parameter int COLS         = 10,
    parameter int FUSE_FRAMES  = 60,
    parameter int BLAST_FRAMES = 30,
    parameter int SLOTS        = 4
) (
    input  logic                     pixel_clk,
    input  logic                     rst_n,
    input  logic                     vsync,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [3:0]               cmd_row,
    input  logic [3:0]               cmd_col,
    input  logic [1:0]               cmd_data,
    output logic                     err,
    output logic                     frame_tick,
    output logic [2*COLS*COLS-1:0]   arena_flat,
    output logic [2*COLS*COLS-1:0]   bomb_flat
);

    localparam int CELLS = COLS * COLS;
    localparam int MW    = 2 * CELLS;
    localparam int HALF  = FUSE_FRAMES / 2;
    localparam int MAXC  = (HALF > BLAST_FRAMES) ? HALF : BLAST_FRAMES;
    localparam int CW    = $clog2(MAXC + 1);
    localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    localparam logic [4:0] C_COLS = 5'(COLS);

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_BOMB  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_ALL   = 2'd3;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FUSE_A = 2'd1;
    localparam logic [1:0] S_FUSE_B = 2'd2;
    localparam logic [1:0] S_BLAST  = 2'd3;

    logic            vsync_d;
    logic            vsync_seen;
    logic            commit;
    logic [MW-1:0]   shadow;
    logic [MW-1:0]   bomb_next;

    logic [1:0]      slot_st    [SLOTS];
    logic [CW-1:0]   slot_cnt   [SLOTS];
    logic            slot_fresh [SLOTS];
    logic [3:0]      slot_row   [SLOTS];
    logic [3:0]      slot_col   [SLOTS];

    logic            frame_edge;
    logic            accept;
    logic            in_bounds;
    int              cell_idx;
    logic [1:0]      shadow_cell;
    logic            free_found;
    logic [SW-1:0]   free_slot;
    logic            dup;
    logic            reject;

    // vsync_seen keeps a reset released while vsync is already low from
    // being mistaken for a falling edge (vsync_d resets high).
    assign frame_edge = vsync_d & ~vsync & vsync_seen;
    assign cmd_ready  = ~(frame_edge | commit);
    assign accept     = cmd_valid & cmd_ready;
    assign in_bounds  = ({1'b0, cmd_row} < C_COLS) && ({1'b0, cmd_col} < C_COLS);

    always_comb begin
        cell_idx    = in_bounds ? (int'(cmd_row) * COLS + int'(cmd_col)) : 0;
        shadow_cell = shadow[2*cell_idx +: 2];
        free_found  = 1'b0;
        free_slot   = '0;
        dup         = 1'b0;
        // Walk downwards so the lowest-index idle slot wins.
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (slot_st[s] == S_IDLE) begin
                free_found = 1'b1;
                free_slot  = SW'(s);
            end else if (slot_row[s] == cmd_row && slot_col[s] == cmd_col) begin
                dup = 1'b1;
            end
        end
        case (cmd_op)
            OP_WRITE, OP_CLEAR: reject = ~in_bounds;
            OP_BOMB:            reject = ~in_bounds | ~free_found | dup |
                                         (shadow_cell != 2'd0);
            default:            reject = 1'b0;
        endcase
    end

    // Bomb map is rebuilt from slot states; blast marks overwrite fuse marks.
    always_comb begin
        int k;
        k         = 0;
        bomb_next = '0;
        for (int s = 0; s < SLOTS; s++) begin
            k = int'(slot_row[s]) * COLS + int'(slot_col[s]);
            if (slot_st[s] == S_FUSE_A) bomb_next[2*k +: 2] = 2'd1;
            if (slot_st[s] == S_FUSE_B) bomb_next[2*k +: 2] = 2'd2;
        end
        for (int s = 0; s < SLOTS; s++) begin
            k = int'(slot_row[s]) * COLS + int'(slot_col[s]);
            if (slot_st[s] == S_BLAST) begin
                bomb_next[2*k +: 2] = 2'd3;
                if (slot_row[s] != 4'd0 && shadow[2*(k-COLS) +: 2] != 2'd1)
                    bomb_next[2*(k-COLS) +: 2] = 2'd3;
                if ({1'b0, slot_row[s]} < C_COLS - 5'd1 && shadow[2*(k+COLS) +: 2] != 2'd1)
                    bomb_next[2*(k+COLS) +: 2] = 2'd3;
                if (slot_col[s] != 4'd0 && shadow[2*(k-1) +: 2] != 2'd1)
                    bomb_next[2*(k-1) +: 2] = 2'd3;
                if ({1'b0, slot_col[s]} < C_COLS - 5'd1 && shadow[2*(k+1) +: 2] != 2'd1)
                    bomb_next[2*(k+1) +: 2] = 2'd3;
            end
        end
    end

    // Shadow arena and slot timers. Commands are never accepted on the
    // frame-edge cycle, so timer steps and command updates never overlap.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                slot_st[s]    <= S_IDLE;
                slot_cnt[s]   <= '0;
                slot_fresh[s] <= 1'b0;
                slot_row[s]   <= '0;
                slot_col[s]   <= '0;
            end
        end else begin
            if (frame_edge) begin
                for (int s = 0; s < SLOTS; s++) begin
                    if (slot_st[s] != S_IDLE) begin
                        if (slot_fresh[s]) begin
                            slot_fresh[s] <= 1'b0;
                        end else if (slot_cnt[s] == CW'(1)) begin
                            case (slot_st[s])
                                S_FUSE_A: begin
                                    slot_st[s]  <= S_FUSE_B;
                                    slot_cnt[s] <= CW'(HALF);
                                end
                                S_FUSE_B: begin
                                    slot_st[s]  <= S_BLAST;
                                    slot_cnt[s] <= CW'(BLAST_FRAMES);
                                end
                                default: begin
                                    slot_st[s]  <= S_IDLE;
                                    slot_cnt[s] <= '0;
                                end
                            endcase
                        end else begin
                            slot_cnt[s] <= slot_cnt[s] - 1'b1;
                        end
                    end
                end
            end
            if (accept && !reject) begin
                case (cmd_op)
                    OP_WRITE: shadow[2*cell_idx +: 2] <= cmd_data;
                    OP_CLEAR: shadow[2*cell_idx +: 2] <= 2'd0;
                    OP_BOMB: begin
                        slot_st[free_slot]    <= S_FUSE_A;
                        slot_cnt[free_slot]   <= CW'(HALF);
                        slot_fresh[free_slot] <= 1'b1;
                        slot_row[free_slot]   <= cmd_row;
                        slot_col[free_slot]   <= cmd_col;
                    end
                    default: begin
                        shadow <= '0;
                        for (int s = 0; s < SLOTS; s++) begin
                            slot_st[s]    <= S_IDLE;
                            slot_fresh[s] <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    // Frame edge detection, commit and registered outputs.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d    <= 1'b1;
            vsync_seen <= 1'b0;
            commit     <= 1'b0;
            frame_tick <= 1'b0;
            err        <= 1'b0;
            arena_flat <= '0;
            bomb_flat  <= '0;
        end else begin
            vsync_d    <= vsync;
            vsync_seen <= vsync_seen | vsync;
            commit     <= frame_edge;
            frame_tick <= commit;
            err        <= accept & reject;
            if (commit) begin
                arena_flat <= shadow;
                bomb_flat  <= bomb_next;
            end
        end
    end

endmodule
`default_nettype wire
